// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer : iterative RV32M multiply/divide unit (shift-add / restoring)
// Revision 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last_it = CNT_W'(XLEN - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    counter_q;
    logic [2:0]          funct3_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic [XLEN-1:0]     op_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     result_q;
    logic                result_valid_q;
    logic                busy_q;

    logic                w_signed_a;
    logic                w_signed_b;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_zero;
    logic                w_overflow;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_shift;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [XLEN-1:0]     w_new_rem;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    assign start_ready  = (state_q == S_IDLE) && !flush;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign busy         = busy_q;

    // Operand decode on the request side, used only in the accept cycle.
    always_comb begin
        w_signed_a    = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        w_signed_b    = funct3[2] ? !funct3[0] : !funct3[1];
        w_sign_a      = w_signed_a && op_a[XLEN-1];
        w_sign_b      = w_signed_b && op_b[XLEN-1];
        w_abs_a       = w_sign_a ? -op_a : op_a;
        w_abs_b       = w_sign_b ? -op_b : op_b;
        w_div_zero    = funct3[2] && (op_b == '0);
        w_overflow    = funct3[2] && !funct3[0] && (op_a == c_int_min) && (op_b == '1);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? op_a : '1;
        end else if (w_overflow) begin
            w_special_res = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration: acc high half is product/remainder, low half is multiplier/quotient.
    always_comb begin
        w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        w_div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_div_ge    = (w_div_shift >= {1'b0, op_q});
        w_div_diff  = w_div_shift[XLEN-1:0] - op_q;
        w_new_rem   = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
        acc_d       = {w_mul_sum, acc_q[XLEN-1:1]};
        if (funct3_q[2]) begin
            acc_d = {w_new_rem, acc_q[XLEN-2:0], w_div_ge};
        end
    end

    always_comb begin
        w_prod  = (sign_a_q ^ sign_b_q) ? -acc_d : acc_d;
        w_quo   = (sign_a_q ^ sign_b_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        w_rem   = sign_a_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        w_final = w_prod[2*XLEN-1:XLEN];
        if (funct3_q[2]) begin
            w_final = funct3_q[1] ? w_rem : w_quo;
        end else if (funct3_q[1:0] == 2'b00) begin
            w_final = w_prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            counter_q      <= '0;
            funct3_q       <= '0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            op_q           <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else if (flush) begin
            state_q        <= S_IDLE;
            counter_q      <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        funct3_q  <= funct3;
                        sign_a_q  <= w_sign_a;
                        sign_b_q  <= w_sign_b;
                        counter_q <= '0;
                        busy_q    <= 1'b1;
                        if (w_div_zero || w_overflow) begin
                            result_q       <= w_special_res;
                            result_valid_q <= 1'b1;
                            state_q        <= S_DONE;
                        end else begin
                            op_q    <= funct3[2] ? w_abs_b : w_abs_a;
                            acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? w_abs_a : w_abs_b)};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (counter_q == c_last_it) begin
                        result_q       <= w_final;
                        result_valid_q <= 1'b1;
                        state_q        <= S_DONE;
                    end else begin
                        counter_q <= counter_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op with result_ready high; lat is the number of negedge samples
    // after the accept edge up to and including the first with result_valid.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        res = '0;
        lat = 0;
        bcnt = 0;
        start_valid = 1'b1;
        funct3 = f;
        op_a = a;
        op_b = b;
        result_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start_valid = 1'b0;
                funct3 = 3'($urandom);
                op_a = $urandom;
                op_b = $urandom;
            end
            lat++;
            if (busy) bcnt++;
            if (result_valid) begin
                res = result;
                break;
            end
        end
        @(negedge clk);
        if (busy) bcnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start_valid = 1'b0;
        funct3 = '0;
        op_a = '0;
        op_b = '0;
        flush = 1'b0;
        result_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int lat, bc;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL mul_back_idle busy=%b start_ready=%b exp 0/1", busy, start_ready); end
    endtask

    task automatic test_mulh();
        logic [31:0] r;
        int lat, bc;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, bc);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL mulh got=%h exp=40000000", r); end
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL mul_m1 got=%h exp=00000001", r); end
        run_op(3'b011, 32'h12345678, 32'h00010000, r, lat, bc);
        checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL mulhu_shift got=%h exp=00001234", r); end
    endtask

    task automatic test_div();
        logic [31:0] r;
        int lat, bc;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got=%0d exp=33", lat); end
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu got=%h exp=0000000e", r); end
        run_op(3'b111, 32'd100, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu got=%h exp=00000002", r); end
        run_op(3'b100, 32'd20, 32'hFFFFFFFA, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb got=%h exp=fffffffd", r); end
    endtask

    task automatic test_special();
        logic [31:0] r;
        int lat, bc;
        run_op(3'b101, 32'd5, 32'd0, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF || lat !== 1) begin errors++; $display("FAIL divu_by0 got=%h lat=%0d exp=ffffffff lat=1", r, lat); end
        run_op(3'b110, 32'd5, 32'd0, r, lat, bc);
        checks++; if (r !== 32'd5 || lat !== 1) begin errors++; $display("FAIL rem_by0 got=%h lat=%0d exp=00000005 lat=1", r, lat); end
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'h80000000 || lat !== 1) begin errors++; $display("FAIL div_ovf got=%h lat=%0d exp=80000000 lat=1", r, lat); end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'h0 || lat !== 1) begin errors++; $display("FAIL rem_ovf got=%h lat=%0d exp=00000000 lat=1", r, lat); end
        run_op(3'b100, 32'd9, 32'd0, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF || lat !== 1) begin errors++; $display("FAIL div_by0 got=%h lat=%0d exp=ffffffff lat=1", r, lat); end
    endtask

    task automatic test_backpressure();
        int seen;
        result_ready = 1'b0;
        start_valid = 1'b1;
        funct3 = 3'b101;
        op_a = 32'd100;
        op_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        op_a = 32'd9;
        op_b = 32'd3;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            if (result_valid) seen = 1;
            else @(negedge clk);
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL bp_timeout got=%0d exp=1", seen); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result !== 32'd14 || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b result=%h start_ready=%b exp 1/0000000e/0", i, result_valid, result, start_ready);
            end
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL bp_release busy=%b start_ready=%b valid=%b exp 0/1/0", busy, start_ready, result_valid); end
        @(negedge clk);
        start_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_pending_accept busy=%b exp=1", busy); end
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            if (result_valid) seen = 1;
            else @(negedge clk);
        end
        checks++; if (result !== 32'd3 || seen != 1) begin errors++; $display("FAIL bp_pending_result got=%h exp=00000003", result); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat, bc, seen;
        result_ready = 1'b1;
        start_valid = 1'b1;
        funct3 = 3'b101;
        op_a = 32'd1000;
        op_b = 32'd3;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL flush_idle busy=%b valid=%b exp 0/0", busy, result_valid); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result seen=%0d exp=0", seen); end
        run_op(3'b101, 32'd9, 32'd3, r, lat, bc);
        checks++; if (r !== 32'd3 || lat !== 33) begin errors++; $display("FAIL flush_after got=%h lat=%0d exp=00000003 lat=33", r, lat); end
        flush = 1'b1;
        start_valid = 1'b1;
        funct3 = 3'b000;
        op_a = 32'd2;
        op_b = 32'd2;
        #1;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL flush_start_ready got=%b exp=0", start_ready); end
        @(negedge clk);
        flush = 1'b0;
        start_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_no_accept busy=%b exp=0", busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_valid = 1'b1;
        funct3 = 3'b000;
        op_a = 32'd5;
        op_b = 32'd6;
        result_ready = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl busy=%b valid=%b exp 0/0", busy, result_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=00000000", result); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rstmid_start_ready got=%b exp=1", start_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_lost valid=%b busy=%b exp 0/0", result_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
